demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- Inverse of the team's 32:1 select mux.
- One 2-bit input stream, tagged with a 5-bit destination select, is routed to one of 32 output channels.
- Each output channel has a one-entry holding register and its own valid/ready handshake.
- Sits upstream of per-channel consumers; lets one producer feed 32 independent sinks without losing data when a sink stalls.

Parameters:
- NUM_OUT, 32, number of implemented output channels (1..32); select values >= NUM_OUT are out of range.
- DW, 2, data width per channel.
- SW, 5, select width; must satisfy 2**SW >= NUM_OUT.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept the beat on in_sel this cycle
- in_sel  input  SW  destination channel index
- in_data  input  DW  payload
- out_valid  output  NUM_OUT  per-channel holding register full
- out_ready  input  NUM_OUT  per-channel consumer accepts
- out_data  output  NUM_OUT*DW  channel i payload at bits [i*DW +: DW]
- drop_cnt  output  CNT_W  count of beats discarded for out-of-range select
- busy  output  1  OR of all out_valid bits

Behaviour:
- Reset (async, immediate on rst=1):
  - all out_valid=0, all out_data=0, drop_cnt=0, busy=0.
  - Any beat in flight is lost; no partial state survives.
- Per-channel state: vld[i] (drives out_valid[i]) and dat[i] (drives out_data slice i). Both are registered outputs; no combinational path from in_* to out_*.
- in_ready is combinational from in_sel, vld and out_ready, and is independent of in_valid:
  - in_sel >= NUM_OUT: in_ready=1.
  - otherwise: in_ready = !vld[in_sel] | out_ready[in_sel].
- Accept = in_valid & in_ready. Latency is 1 cycle: a beat accepted at edge N shows on out_valid/out_data of channel in_sel after edge N.
- Channel i update at each clock edge, in priority order:
  1. push (accept with in_sel==i): dat[i]<=in_data, vld[i]<=1. If out_ready[i] is also high in the same cycle, the old beat is consumed and the new one replaces it; vld stays 1. Full throughput: 1 beat/cycle per channel.
  2. pop only (vld[i] & out_ready[i], no push): vld[i]<=0; dat[i] holds its last value.
  3. otherwise: hold.
- Stall: while vld[i] & !out_ready[i], out_data slice i is stable, and in_ready=0 for in_sel==i. Other channels are unaffected; no head-of-line blocking beyond the current beat.
- Out-of-range select (in_sel >= NUM_OUT): the beat is accepted and discarded, and drop_cnt increments by 1.
  - drop_cnt saturates at 2**CNT_W-1 (255) and does not wrap.
  - drop_cnt is cleared only by rst.
- in_valid=0: no state change except pops.
- out_ready for a channel with vld=0 is ignored.
- Changing in_sel or in_data while in_valid=1 and in_ready=0 is legal; there is no sticky-request requirement.
- busy is registered-equivalent: the OR of the registered vld bits.

Test Plan:
- Reset: assert rst mid-run with channels 3 and 17 full -> out_valid=0 and drop_cnt=0 immediately, before the next clk edge; out_data=0.
- Basic route: rst released, out_ready=all 1; send in_sel=5, in_data=2'b10 for one cycle -> next cycle out_valid=32'h0000_0020, out_data[11:10]=2'b10; following cycle out_valid=0.
- Stall/backpressure: out_ready[9]=0; send sel=9 data=1 -> accepted. Then send sel=9 data=3 -> in_ready=0, channel 9 holds 1. Present sel=10 data=2 in the same stall -> in_ready=1, channel 10 gets 2. Raise out_ready[9] -> the data=3 beat is accepted that cycle and appears next cycle.
- Simultaneous push/pop: channel 0 full with 2'b01 and out_ready[0]=1; send sel=0 data=2'b11 -> out_valid[0] stays 1, out_data[1:0]=2'b11 next cycle.
- Streaming: 32 back-to-back beats, sel=0..31, data=sel[1:0], out_ready=all 1 -> each channel pulses valid exactly once with the correct data; in_ready=1 throughout.
- Out of range: with NUM_OUT=30, send sel=30 and sel=31 -> both accepted, no out_valid asserted, drop_cnt=2. Then send 300 more such beats -> drop_cnt=255, saturated.

Source files
------------

// File: rtl/demux_router.sv
// demux_router: routes one tagged input stream to NUM_OUT channels.
// Each channel owns a one-entry holding register with valid/ready.
module demux_router #(
    parameter int NUM_OUT = 32,
    parameter int DW      = 2,
    parameter int SW      = 5,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SW-1:0]         in_sel,
    input  logic [DW-1:0]         in_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [NUM_OUT*DW-1:0] out_data,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic                  busy
);

    logic [NUM_OUT-1:0]    vld;
    logic [NUM_OUT*DW-1:0] dat;
    logic [NUM_OUT-1:0]    hit;
    logic                  in_range;
    logic                  sel_vld;
    logic                  sel_rdy;
    logic                  acc;

    // Decode the select into a one-hot channel hit and pick its state.
    always_comb begin
        in_range = 32'(in_sel) < NUM_OUT;
        hit      = '0;
        sel_vld  = 1'b0;
        sel_rdy  = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (in_sel == SW'(i)) begin
                hit[i]  = 1'b1;
                sel_vld = vld[i];
                sel_rdy = out_ready[i];
            end
        end
    end

    // Out-of-range beats are always taken (and discarded).
    assign in_ready = !in_range || !sel_vld || sel_rdy;
    assign acc      = in_valid && in_ready;

    // Per-channel holding registers: push wins over pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            dat <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (acc && hit[i]) begin
                    vld[i]          <= 1'b1;
                    dat[i*DW +: DW] <= in_data;
                end else if (out_ready[i]) begin
                    vld[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of beats discarded for an out-of-range select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (acc && !in_range && drop_cnt != {CNT_W{1'b1}}) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign out_valid = vld;
    assign out_data  = dat;
    assign busy      = |vld;

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: directed stimulus with per-channel expected-data
// queues drained by an independent monitor on every output handshake.
module tb_demux_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_sel;
    logic [1:0]  in_data;
    logic [31:0] out_ready;

    logic        a_in_ready;
    logic [31:0] a_ov;
    logic [63:0] a_od;
    logic [7:0]  a_drop;
    logic        a_busy;

    logic        b_in_ready;
    logic [29:0] b_ov;
    logic [59:0] b_od;
    logic [7:0]  b_drop;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] q [32][$];

    demux_router u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (a_ov),
        .out_ready (out_ready),
        .out_data  (a_od),
        .drop_cnt  (a_drop),
        .busy      (a_busy)
    );

    demux_router #(.NUM_OUT(30)) u_d30 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (b_ov),
        .out_ready (out_ready[29:0]),
        .out_data  (b_od),
        .drop_cnt  (b_drop),
        .busy      (b_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat on the 32-channel instance with a known ready answer.
    task automatic beat(input int sel, input logic [1:0] d,
                        input logic er);
        in_valid = 1'b1;
        in_sel   = sel[4:0];
        in_data  = d;
        @(negedge clk);
        chk($sformatf("in_ready sel%0d", sel), 64'(a_in_ready), 64'(er));
        if (er) q[sel].push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every handshake on the 32-channel instance pops a beat.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                if (a_ov[i] && out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ch%0d extra beat: got %0h expected none",
                                 i, a_od[i*2 +: 2]);
                    end else begin
                        chk($sformatf("ch%0d data", i),
                            64'(a_od[i*2 +: 2]), 64'(q[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(a_ov), 0);
        chk("reset out_data", a_od, 0);
        chk("reset drop_cnt", 64'(a_drop), 0);
        chk("reset busy", 64'(a_busy), 0);
        rst = 1'b0;
        tick();

        // basic route
        beat(5, 2'b10, 1'b1);
        chk("route out_valid", 64'(a_ov), 64'h20);
        chk("route data", 64'(a_od[11:10]), 2);
        chk("route busy", 64'(a_busy), 1);
        tick();
        chk("route drained", 64'(a_ov), 0);

        // backpressure on channel 9
        out_ready[9] = 1'b0;
        beat(9, 2'd1, 1'b1);
        chk("stall v9", 64'(a_ov[9]), 1);
        chk("stall d9", 64'(a_od[19:18]), 1);
        beat(9, 2'd3, 1'b0);
        chk("stall hold d9", 64'(a_od[19:18]), 1);
        beat(10, 2'd2, 1'b1);
        chk("bypass v10", 64'(a_ov[10]), 1);
        chk("bypass d10", 64'(a_od[21:20]), 2);
        chk("bypass hold d9", 64'(a_od[19:18]), 1);
        out_ready[9] = 1'b1;
        beat(9, 2'd3, 1'b1);
        chk("release d9", 64'(a_od[19:18]), 3);
        chk("release v9", 64'(a_ov[9]), 1);
        tick();
        chk("release drained", 64'(a_ov), 0);

        // simultaneous push and pop on channel 0
        out_ready[0] = 1'b0;
        beat(0, 2'b01, 1'b1);
        chk("pp d0 first", 64'(a_od[1:0]), 1);
        out_ready[0] = 1'b1;
        beat(0, 2'b11, 1'b1);
        chk("pp v0", 64'(a_ov[0]), 1);
        chk("pp d0", 64'(a_od[1:0]), 3);
        tick();
        chk("pp popped", 64'(a_ov[0]), 0);
        chk("pp data held", 64'(a_od[1:0]), 3);

        // back-to-back stream over every channel
        for (int s = 0; s < 32; s++) begin
            beat(s, s[1:0], 1'b1);
        end
        tick();
        chk("stream drained", 64'(a_ov), 0);
        chk("stream busy", 64'(a_busy), 0);
        chk("d30 drop after stream", 64'(b_drop), 2);

        // asynchronous reset with channels 3 and 17 full
        out_ready[3]  = 1'b0;
        out_ready[17] = 1'b0;
        beat(3, 2'd2, 1'b1);
        beat(17, 2'd1, 1'b1);
        chk("pre-rst out_valid", 64'(a_ov), 64'h0002_0008);
        chk("pre-rst d3", 64'(a_od[7:6]), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(a_ov), 0);
        chk("async rst out_data", a_od, 0);
        chk("async rst busy", 64'(a_busy), 0);
        chk("async rst drop_cnt", 64'(b_drop), 0);
        chk("async rst d30 valid", 64'(b_ov), 0);
        q[3].delete();
        q[17].delete();
        out_ready = '1;
        tick();
        rst = 1'b0;
        tick();

        // out-of-range selects on the 30-channel instance
        for (int k = 0; k < 302; k++) begin
            in_valid = 1'b1;
            in_sel   = 5'd30 + 5'(k % 2);
            in_data  = k[1:0];
            @(negedge clk);
            chk("oor in_ready", 64'(b_in_ready), 1);
            chk("a in_ready", 64'(a_in_ready), 1);
            q[30 + (k % 2)].push_back(k[1:0]);
            @(posedge clk);
            #1;
            if (k < 2) chk("oor no valid", 64'(b_ov), 0);
            if (k == 1) chk("drop two", 64'(b_drop), 2);
            if (k == 253) chk("drop 254", 64'(b_drop), 254);
        end
        in_valid = 1'b0;
        chk("drop saturated", 64'(b_drop), 255);
        tick();
        chk("drop held", 64'(b_drop), 255);
        tick();

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("q%0d empty", i), 64'(q[i].size()), 0);
        end
        chk("final out_valid", 64'(a_ov), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
